wide_add_sequencer: RTL and testbench

Multi-precision add/subtract sequencer built around a single 16-bit Brent-Kung prefix adder instance. It accepts one wide operation of WORDS×16 bits through a valid/ready handshake. It steps the shared 16-bit adder over the operand one word per cycle, least-significant word first, and carries between words through a register. It then presents the wide result with carry-out and signed overflow on a valid/ready output. The block is the team's area-optimised alternative to a flat wide prefix adder.

---
 rtl/wide_add_sequencer.sv | 165 ++++++++++++++++
 tb/tb_wide_add_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract that reuses one 16-bit Brent-Kung adder for WORDS cycles, LSW first.
// Result and flags are registered and held in DONE until the consumer takes them.
`timescale 1ns/1ps

module bk_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p, gg, pp;
  logic [16:0] c;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = g;
    pp = p;
    // up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 16; i++) begin
        if ((i % (2 << d)) == (2 << d) - 1) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
          pp[i] = pp[i] & pp[i - (1 << d)];
        end
      end
    end
    for (int d = 2; d >= 0; d--) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (2 << d) && (i % (2 << d)) == (1 << d) - 1) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
          pp[i] = pp[i] & pp[i - (1 << d)];
        end
      end
    end
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      c[i + 1] = gg[i] | (pp[i] & cin);
    end
    sum  = p ^ c[15:0];
    cout = c[16];
  end
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_sub,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  busy
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;

  logic [15:0]     a_word, b_word, add_sum;
  logic            add_cout;

  bk_add16 u_add (
    .a    (a_word),
    .b    (b_word),
    .cin  (cy_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        a_word = a_q[16*k +: 16];
        b_word = b_q[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          cy_d    = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == IW'(k)) sum_d[16*k +: 16] = add_sum;
        end
        cy_d = add_cout;
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_cout;
          ovf_d   = (a_word[15] == b_word[15]) & (add_sum[15] != a_word[15]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed literal cases on a 4-word instance, then random traffic
// on 4-word and 1-word instances against a plain-arithmetic model of the wide result.
`timescale 1ns/1ps

module tb_wide_add_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        iv4, ir4, sub4, cin4, ov4, or4, cout4, ovf4, busy4;
  logic [63:0] a4, b4, sum4;
  logic        iv1, ir1, sub1, cin1, ov1, or1, cout1, ovf1, busy1;
  logic [15:0] a1, b1, sum1;

  wide_add_sequencer #(.WORDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_sub(sub4), .in_cin(cin4), .out_valid(ov4), .out_ready(or4), .out_sum(sum4),
    .out_cout(cout4), .out_ovf(ovf4), .busy(busy4)
  );

  wide_add_sequencer #(.WORDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .in_sub(sub1), .in_cin(cin1), .out_valid(ov1), .out_ready(or1), .out_sum(sum1),
    .out_cout(cout1), .out_ovf(ovf1), .busy(busy1)
  );

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic pend [2] = '{1'b0, 1'b0};
  int   acc  [2] = '{0, 0};
  int   done_ops [2] = '{0, 0};
  res_t exp_r [2];

  function automatic int wn_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Wide result from ordinary unsigned/signed arithmetic on lw-bit operands.
  function automatic res_t model(int wn, logic [63:0] a_in, logic [63:0] b_in, logic sub, logic cin);
    res_t r;
    int lw;
    logic [64:0] mask, full;
    logic [63:0] a, b;
    logic signed [66:0] sa, sb, sr, smax;
    lw = 16 * wn;
    mask = (65'd1 << lw) - 65'd1;
    a = a_in & mask[63:0];
    b = b_in & mask[63:0];
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    r.sum  = full[63:0] & mask[63:0];
    r.cout = sub ? (a >= b) : full[lw];
    sa = $signed({3'b0, a});
    if (a[lw-1]) sa = sa - (67'sd1 <<< lw);
    sb = $signed({3'b0, b});
    if (b[lw-1]) sb = sb - (67'sd1 <<< lw);
    sr = sub ? (sa - sb) : (sa + sb + $signed({66'd0, cin}));
    smax = (67'sd1 <<< (lw - 1)) - 67'sd1;
    r.ovf = (sr > smax) || (sr < (-smax - 67'sd1));
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input int i, input logic iv, input logic orr, input logic [63:0] a,
                      input logic [63:0] b, input logic sub, input logic cin);
    if (pend[i]) begin
      if ((cyc - acc[i] >= wn_of(i)) && orr) begin
        pend[i] = 1'b0;
        done_ops[i]++;
      end
    end else if (iv) begin
      pend[i]  = 1'b1;
      acc[i]   = cyc + 1;
      exp_r[i] = model(wn_of(i), a, b, sub, cin);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      step(0, iv4, or4, a4, b4, sub4, cin4);
      step(1, iv1, or1, {48'd0, a1}, {48'd0, b1}, sub1, cin1);
    end
    cyc = cyc + 1;
  end

  task automatic compare(input int i, input logic ir, input logic bz, input logic ov,
                         input logic [63:0] s, input logic co, input logic of);
    logic ev;
    if (!rst_n) begin
      check($sformatf("w%0d reset out_valid", wn_of(i)), 64'(ov), 64'd0);
      check($sformatf("w%0d reset in_ready", wn_of(i)), 64'(ir), 64'd1);
    end else begin
      ev = pend[i] && (cyc - acc[i] >= wn_of(i));
      check($sformatf("w%0d in_ready", wn_of(i)), 64'(ir), 64'(!pend[i]));
      check($sformatf("w%0d busy", wn_of(i)), 64'(bz), 64'(pend[i]));
      check($sformatf("w%0d out_valid", wn_of(i)), 64'(ov), 64'(ev));
      if (ev) begin
        check($sformatf("w%0d out_sum", wn_of(i)), s, exp_r[i].sum);
        check($sformatf("w%0d out_cout", wn_of(i)), 64'(co), 64'(exp_r[i].cout));
        check($sformatf("w%0d out_ovf", wn_of(i)), 64'(of), 64'(exp_r[i].ovf));
      end
    end
  endtask

  always @(negedge clk) begin
    compare(0, ir4, busy4, ov4, sum4, cout4, ovf4);
    compare(1, ir1, busy1, ov1, {48'd0, sum1}, cout1, ovf1);
  end

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    return {rnd16(), rnd16(), rnd16(), rnd16()};
  endfunction

  task automatic op4(input string name, input logic [63:0] a, input logic [63:0] b, input logic sub,
                     input logic cin, input logic [63:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; sub4 = sub; cin4 = cin; iv4 = 1'b1; or4 = 1'b1;
    check({name, " in_ready"}, 64'(ir4), 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd4);
    check({name, " sum"}, sum4, es);
    check({name, " cout"}, 64'(cout4), 64'(ec));
    check({name, " ovf"}, 64'(ovf4), 64'(eo));
    @(posedge clk);
  endtask

  task automatic backpressure();
    int n;
    @(negedge clk);
    a4 = 64'h0123_4567_89AB_CDEF; b4 = 64'h1111_1111_1111_1111; sub4 = 1'b0; cin4 = 1'b0;
    iv4 = 1'b1; or4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      check("bp out_valid", 64'(ov4), 64'd1);
      check("bp in_ready", 64'(ir4), 64'd0);
      check("bp busy", 64'(busy4), 64'd1);
      check("bp sum", sum4, 64'h1234_5678_9ABC_DF00);
      check("bp cout", 64'(cout4), 64'd0);
      check("bp ovf", 64'(ovf4), 64'd0);
      iv4 = 1'b1; a4 = rnd64(); b4 = rnd64(); cin4 = 1'($urandom);
      @(negedge clk);
    end
    a4 = 64'd2; b4 = 64'd3; cin4 = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 64'(ir4), 64'd1);
    check("bp release out_valid", 64'(ov4), 64'd0);
    @(negedge clk);
    check("bp pending accepted", 64'(busy4), 64'd1);
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp pending sum", sum4, 64'd5);
    @(posedge clk);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    a4 = 64'hFFFF_FFFF_FFFF_FFFF; b4 = 64'd1; sub4 = 1'b0; cin4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst out_valid", 64'(ov4), 64'd0);
    check("rst busy", 64'(busy4), 64'd0);
    check("rst sum_q", u4.sum_q, 64'd0);
    check("rst cy_q", 64'(u4.cy_q), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op4("after reset", 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);
  endtask

  task automatic rand4();
    int guard = 0;
    while (done_ops[0] < 2000 && guard < 60000) begin
      @(negedge clk);
      guard++;
      iv4 = ($urandom_range(0, 2) != 0);
      a4 = rnd64(); b4 = rnd64();
      sub4 = 1'($urandom); cin4 = 1'($urandom);
      or4 = ($urandom_range(0, 2) != 0);
    end
    iv4 = 1'b0; or4 = 1'b1;
    check("w4 random ops completed", 64'(done_ops[0] >= 2000), 64'd1);
  endtask

  task automatic rand1();
    int guard = 0;
    while (done_ops[1] < 2000 && guard < 60000) begin
      @(negedge clk);
      guard++;
      iv1 = ($urandom_range(0, 2) != 0);
      a1 = rnd16(); b1 = rnd16();
      sub1 = 1'($urandom); cin1 = 1'($urandom);
      or1 = ($urandom_range(0, 2) != 0);
    end
    iv1 = 1'b0; or1 = 1'b1;
    check("w1 random ops completed", 64'(done_ops[1] >= 2000), 64'd1);
  endtask

  initial begin
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; sub4 = 1'b0; cin4 = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; sub1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sum", sum4, 64'd0);
    check("reset cout", 64'(cout4), 64'd0);
    check("reset ovf", 64'(ovf4), 64'd0);
    check("reset busy", 64'(busy4), 64'd0);
    rst_n = 1'b1;

    op4("add ffff+1", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    op4("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
    op4("add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op4("sub 5-7", 64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op4("sub ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    op4("sub 5-7 cin", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op4("sub ovf cin", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    backpressure();
    reset_mid_run();

    fork
      rand4();
      rand1();
    join
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
